// File: rtl/fix_to_single_pipe.sv
// Fixed-point (signed/unsigned, W<=64) to IEEE 754 single converter; FIX_TO_SINGLE_ROUND_EN selects RNE over truncation.
// Latency: 3 cycles accept-to-out_valid, one result per clock when unstalled.
// Backpressure: per-stage valid flags with bubble collapse; holds up to 3 samples while out_ready is low.
module fix_to_single_pipe #(
    parameter int INT_WIDTH   = 12,
    parameter int FRACT_WIDTH = 4,
    parameter int SIGNED      = 1,
    parameter int TAG_WIDTH   = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [INT_WIDTH+FRACT_WIDTH-1:0]   in_data,
    input  logic [TAG_WIDTH-1:0]               in_tag,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [31:0]                        out_data,
    output logic [TAG_WIDTH-1:0]               out_tag,
    output logic                               out_inexact
);
    localparam int W   = INT_WIDTH + FRACT_WIDTH;
    localparam int FW  = W - 1;
    localparam int LZW = 7;

    logic                 r_s1_vld, r_s1_sign, r_s1_zero;
    logic [W-1:0]         r_s1_mag;
    logic [TAG_WIDTH-1:0] r_s1_tag;
    logic                 r_s2_vld, r_s2_sign, r_s2_zero;
    logic [FW-1:0]        r_s2_frac;
    logic [LZW-1:0]       r_s2_lz;
    logic [TAG_WIDTH-1:0] r_s2_tag;
    logic                 r_s3_vld;
    logic [31:0]          r_out_data;
    logic [TAG_WIDTH-1:0] r_out_tag;
    logic                 r_out_inexact;

    logic                 w_ld1, w_ld2, w_ld3;
    logic                 w_sign;
    logic [W-1:0]         w_mag;
    logic [LZW-1:0]       w_lz;
    logic [7:0]           w_exp_base, w_exp;
    logic [22:0]          w_mant;
    logic                 w_inexact;

    assign w_ld3    = !r_s3_vld || out_ready;
    assign w_ld2    = !r_s2_vld || w_ld3;
    assign w_ld1    = !r_s1_vld || w_ld2;
    assign in_ready = w_ld1;

    generate
        if (SIGNED != 0) begin : g_signed
            assign w_sign = in_data[W-1];
        end else begin : g_unsigned
            assign w_sign = 1'b0;
        end
    endgenerate

    // Negating the most negative value wraps to 2^(W-1), which is the right unsigned magnitude.
    assign w_mag = w_sign ? -in_data : in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_sign <= 1'b0;
            r_s1_zero <= 1'b0;
            r_s1_mag  <= '0;
            r_s1_tag  <= '0;
        end else if (w_ld1) begin
            r_s1_vld <= in_valid;
            if (in_valid) begin
                r_s1_sign <= w_sign;
                r_s1_zero <= (in_data == '0);
                r_s1_mag  <= w_mag;
                r_s1_tag  <= in_tag;
            end
        end
    end

    always_comb begin
        w_lz = '0;
        for (int i = 0; i < W; i++) begin
            if (r_s1_mag[i]) w_lz = LZW'(W - 1 - i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld  <= 1'b0;
            r_s2_sign <= 1'b0;
            r_s2_zero <= 1'b0;
            r_s2_frac <= '0;
            r_s2_lz   <= '0;
            r_s2_tag  <= '0;
        end else if (w_ld2) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_sign <= r_s1_sign;
                r_s2_zero <= r_s1_zero;
                r_s2_frac <= FW'(r_s1_mag << w_lz);
                r_s2_lz   <= w_lz;
                r_s2_tag  <= r_s1_tag;
            end
        end
    end

    // The hidden leading one is dropped at stage 2, so r_s2_frac holds only fraction bits.
    assign w_exp_base = 8'(127 + INT_WIDTH - 1 - int'(r_s2_lz));

    generate
        if (FW <= 23) begin : g_exact
            assign w_mant    = 23'(r_s2_frac) << (23 - FW);
            assign w_exp     = w_exp_base;
            assign w_inexact = 1'b0;
        end else begin : g_wide
            logic [22:0] w_trunc;
            assign w_trunc   = r_s2_frac[FW-1:FW-23];
            assign w_inexact = |r_s2_frac[FW-24:0];
`ifdef FIX_TO_SINGLE_ROUND_EN
            logic        w_guard, w_sticky, w_inc;
            logic [23:0] w_sum;
            assign w_guard = r_s2_frac[FW-24];
            if (FW > 24) begin : g_sticky
                assign w_sticky = |r_s2_frac[FW-25:0];
            end else begin : g_no_sticky
                assign w_sticky = 1'b0;
            end
            assign w_inc  = w_guard && (w_sticky || w_trunc[0]);
            assign w_sum  = {1'b0, w_trunc} + {23'd0, w_inc};
            assign w_mant = w_sum[22:0];
            assign w_exp  = w_exp_base + {7'd0, w_sum[23]};
`else
            assign w_mant = w_trunc;
            assign w_exp  = w_exp_base;
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3_vld      <= 1'b0;
            r_out_data    <= '0;
            r_out_tag     <= '0;
            r_out_inexact <= 1'b0;
        end else if (w_ld3) begin
            r_s3_vld <= r_s2_vld;
            if (r_s2_vld) begin
                r_out_data    <= r_s2_zero ? 32'd0 : {r_s2_sign, w_exp, w_mant};
                r_out_tag     <= r_s2_tag;
                r_out_inexact <= r_s2_zero ? 1'b0 : w_inexact;
            end
        end
    end

    assign out_valid   = r_s3_vld;
    assign out_data    = r_out_data;
    assign out_tag     = r_out_tag;
    assign out_inexact = r_out_inexact;
endmodule

// File: tb/tb_fix_to_single_pipe.sv
// Bench for fix_to_single_pipe: default 12.4 signed instance plus a 24.8 unsigned instance for rounding.
module tb_fix_to_single_pipe;
`ifdef FIX_TO_SINGLE_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_inexact;
    logic [15:0] a_in_data;
    logic [3:0]  a_in_tag, a_out_tag;
    logic [31:0] a_out_data;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_inexact;
    logic [31:0] b_in_data;
    logic [3:0]  b_in_tag, b_out_tag;
    logic [31:0] b_out_data;

    fix_to_single_pipe #(.INT_WIDTH(12), .FRACT_WIDTH(4), .SIGNED(1), .TAG_WIDTH(4)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_tag(a_out_tag), .out_inexact(a_out_inexact));

    fix_to_single_pipe #(.INT_WIDTH(24), .FRACT_WIDTH(8), .SIGNED(0), .TAG_WIDTH(4)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_tag(b_out_tag), .out_inexact(b_out_inexact));

    typedef struct {
        logic [31:0] dat;
        logic [3:0]  tag;
        logic        inx;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   pops  = 0;

    // Real-valued view: value = mag * 2^-fw, exponent from the top set bit, rounding from the remainder.
    function automatic logic [32:0] model(input logic [63:0] din, input int iw, input int fw,
                                          input bit sgn, input bit rnd);
        int w, p, e, sh;
        logic [63:0] mask, d, mag, m, rem, half;
        bit s, inx;
        w    = iw + fw;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        d    = din & mask;
        s    = sgn && d[w-1];
        mag  = s ? ((~d + 64'd1) & mask) : d;
        if (mag == 64'd0) return 33'd0;
        p = w - 1;
        while (mag[p] == 1'b0) p--;
        e   = 127 + p - fw;
        inx = 1'b0;
        if (p <= 23) begin
            m = mag << (23 - p);
        end else begin
            sh   = p - 23;
            m    = mag >> sh;
            rem  = mag & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            inx  = (rem != 64'd0);
            if (rnd && ((rem > half) || (rem == half && m[0]))) m = m + 64'd1;
            if (m[24]) begin
                m = m >> 1;
                e++;
            end
        end
        return {inx, s, e[7:0], m[22:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", name, obs, expv);
        end
    endtask

    // One clock of stimulus on instance A with scoreboard update.
    task automatic cyc(input logic v, input logic [15:0] d, input logic [3:0] t, input logic r,
                       output logic rdy);
        exp_t        e;
        logic [32:0] mr;
        @(negedge clk);
        a_in_valid  = v;
        a_in_data   = d;
        a_in_tag    = t;
        a_out_ready = r;
        #1;
        rdy = a_in_ready;
        if (a_out_valid && r) begin
            if (q.size() == 0) begin
                check("spurious_out", {31'd0, a_out_valid}, 32'd0);
            end else begin
                e = q.pop_front();
                pops++;
                check("out_data", a_out_data, e.dat);
                check("out_tag", {28'd0, a_out_tag}, {28'd0, e.tag});
                check("out_inexact", {31'd0, a_out_inexact}, {31'd0, e.inx});
            end
        end
        if (v && rdy) begin
            mr    = model({48'd0, d}, 12, 4, 1'b1, ROUND);
            e.dat = mr[31:0];
            e.inx = mr[32];
            e.tag = t;
            q.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic single(input logic [15:0] d, input logic [3:0] t, input logic [31:0] expv);
        @(negedge clk);
        a_in_valid  = 1'b1;
        a_in_data   = d;
        a_in_tag    = t;
        a_out_ready = 1'b1;
        #1 check("dir_in_ready", {31'd0, a_in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 1'b0;
        check("dir_lat1_vld", {31'd0, a_out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("dir_lat2_vld", {31'd0, a_out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("dir_lat3_vld", {31'd0, a_out_valid}, 32'd1);
        check("dir_data", a_out_data, expv);
        check("dir_tag", {28'd0, a_out_tag}, {28'd0, t});
        check("dir_inexact", {31'd0, a_out_inexact}, 32'd0);
    endtask

    task automatic bconv(input logic [31:0] d, input logic [31:0] expv, input logic expi);
        int n;
        @(negedge clk);
        b_in_valid = 1'b1;
        b_in_data  = d;
        b_in_tag   = d[3:0];
        #1 check("b_in_ready", {31'd0, b_in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        b_in_valid = 1'b0;
        n = 1;
        while (!b_out_valid && n < 10) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("b_latency", n, 3);
        check("b_data", b_out_data, expv);
        check("b_inexact", {31'd0, b_out_inexact}, {31'd0, expi});
        check("b_tag", {28'd0, b_out_tag}, {28'd0, d[3:0]});
    endtask

    initial begin
        logic        rdy, acc;
        logic [15:0] bp_d [4];
        logic [32:0] mr;
        logic [31:0] bd;
        int          p0;

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_in_tag = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_in_tag = '0; b_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
        check("rst_out_data", a_out_data, 32'd0);
        check("rst_out_tag", {28'd0, a_out_tag}, 32'd0);
        check("rst_out_inexact", {31'd0, a_out_inexact}, 32'd0);

        single(16'h0010, 4'h1, 32'h3F800000);
        single(16'hFFF0, 4'h2, 32'hBF800000);
        single(16'h0001, 4'h3, 32'h3D800000);
        single(16'h8000, 4'h4, 32'hC5000000);
        single(16'h0000, 4'h5, 32'h00000000);

        // Back-to-back stream.
        p0 = pops;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, 16'($urandom), i[3:0], 1'b1, rdy);
            check("stream_in_ready", {31'd0, rdy}, 32'd1);
        end
        repeat (6) cyc(1'b0, 16'd0, 4'd0, 1'b1, rdy);
        check("stream_count", pops - p0, 100);
        check("stream_q_empty", q.size(), 0);

        // Backpressure: three samples fill the pipe, the fourth waits.
        p0 = pops;
        for (int k = 0; k < 4; k++) bp_d[k] = 16'($urandom);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, bp_d[k], 4'(k), 1'b0, rdy);
            check("bp_in_ready", {31'd0, rdy}, (k < 3) ? 32'd1 : 32'd0);
        end
        mr = model({48'd0, bp_d[0]}, 12, 4, 1'b1, ROUND);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, bp_d[3], 4'd3, 1'b0, rdy);
            check("bp_hold_rdy", {31'd0, rdy}, 32'd0);
            check("bp_hold_vld", {31'd0, a_out_valid}, 32'd1);
            check("bp_hold_data", a_out_data, mr[31:0]);
            check("bp_hold_tag", {28'd0, a_out_tag}, 32'd0);
        end
        acc = 1'b0;
        for (int n = 0; n < 10 && !acc; n++) begin
            cyc(1'b1, bp_d[3], 4'd3, 1'b1, rdy);
            acc = rdy;
        end
        check("bp_fourth_accepted", {31'd0, acc}, 32'd1);
        repeat (6) cyc(1'b0, 16'd0, 4'd0, 1'b1, rdy);
        check("bp_count", pops - p0, 4);
        check("bp_q_empty", q.size(), 0);

        // Reset with three samples in flight.
        for (int k = 0; k < 3; k++) cyc(1'b1, 16'($urandom), 4'(k + 8), 1'b0, rdy);
        @(negedge clk);
        a_in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_vld", {31'd0, a_out_valid}, 32'd0);
        check("rst_mid_rdy", {31'd0, a_in_ready}, 32'd1);
        check("rst_mid_data", a_out_data, 32'd0);
        #1 rst_n = 1'b1;
        q.delete();
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 16'd0, 4'd0, 1'b1, rdy);
            check("rst_post_vld", {31'd0, a_out_valid}, 32'd0);
            check("rst_post_rdy", {31'd0, rdy}, 32'd1);
        end

        // 24.8 unsigned instance: rounding boundaries.
        bconv(32'h01000001, 32'h47800000, 1'b1);
        bconv(32'h01000003, ROUND ? 32'h47800002 : 32'h47800001, 1'b1);
        bconv(32'h01FFFFFF, ROUND ? 32'h48000000 : 32'h47FFFFFF, 1'b1);
        for (int k = 0; k < 20; k++) begin
            bd = (k == 0) ? 32'hFFFFFFFF : $urandom >> $urandom_range(0, 24);
            mr = model({32'd0, bd}, 24, 8, 1'b0, ROUND);
            bconv(bd, mr[31:0], mr[32]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fix_to_single_pipe.md
Name: fix_to_single_pipe

Overview:
- Pipelined, parametrised fixed-point to IEEE 754 single-precision converter with valid/ready handshakes on both sides.
- Adds signed input, configurable width up to 64 bits, round-to-nearest-even and a pass-through tag.
- Sits between fixed-point datapath blocks (fast inverse sqrt, accumulators) and float consumers or the bus-facing register file.
- Three-stage pipeline; sustains one conversion per clock when unstalled.

Parameters:
- INT_WIDTH, 12, integer bits of input (including sign bit when SIGNED=1); 1..63.
- FRACT_WIDTH, 4, fractional bits; INT_WIDTH+FRACT_WIDTH (W) must be 2..64.
- SIGNED, 1, 1 = input is two's complement; 0 = unsigned.
- TAG_WIDTH, 4, width of sideband tag carried alongside each sample; must be at least 1.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  converter can accept the sample this cycle.
- in_data  in  W  fixed-point sample.
- in_tag  in  TAG_WIDTH  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  32  IEEE 754 single.
- out_tag  out  TAG_WIDTH  tag of this result.
- out_inexact  out  1  nonzero bits discarded during conversion.

Behaviour:
- Reset, asynchronous on rst_n low:
  - All stage valid flags clear, so out_valid=0 and in_ready=1 after reset.
  - out_data=0, out_tag=0, out_inexact=0.
  - In-flight samples are discarded; no partial result is emitted after reset release.
- Handshake:
  - Transfer on in_valid&&in_ready, and on out_valid&&out_ready.
  - Each stage n loads when it is empty or stage n+1 loads in the same cycle; stage 3 drains on out_ready.
  - in_ready = !s1_valid || s1_advance, computed combinationally from stage state and out_ready.
  - Bubbles collapse, so up to 3 samples are held during a stall.
  - out_data, out_tag and out_inexact are stable while out_valid && !out_ready.
  - Order is preserved.
- Latency: 3 cycles from input accept to out_valid when out_ready=1.
- Stage 1, sign and magnitude:
  - sign = in_data[W-1] when SIGNED=1, else 0.
  - mag = |in_data| as a W-bit unsigned value. The most negative input gives mag = 2^(W-1), which is correct in W bits.
  - zero flag = (in_data == 0).
- Stage 2, normalise:
  - lz = leading-zero count of mag (0..W-1), implemented with a priority encoder.
  - norm = mag << lz, so norm[W-1]=1 for nonzero mag.
- Stage 3, pack:
  - exp = 127 + (INT_WIDTH-1) - lz, 8 bits; no overflow or underflow is possible for W<=64.
  - If W-1 <= 23: mant = norm[W-2:0] left-aligned and zero-padded; out_inexact=0.
  - If W-1 > 23: mant = norm[W-2:W-24]; discarded bits are norm[W-25:0].
  - Rounding applies per the optional feature.
  - A rounding carry out of mant sets mant=0 and exp=exp+1.
  - out_data = {sign, exp, mant}.
  - Zero input gives 0x00000000 (+0 only, never -0) with out_inexact=0.
- Simultaneous in-accept and out-drain in the same cycle when full: both occur and occupancy is unchanged.

Optional Feature:
- Macro: FIX_TO_SINGLE_ROUND_EN.
- Defined: round-to-nearest, ties-to-even.
  - guard = norm[W-25]; sticky = OR of norm[W-26:0].
  - Increment mant when guard && (sticky || mant[0]).
- Undefined: truncate toward zero (magnitude truncated).
- out_inexact is the same in both modes: any discarded bit nonzero.

Test Plan:
- Defaults (12.4, signed):
  - 0x0010 -> 0x3F800000.
  - 0xFFF0 -> 0xBF800000.
  - 0x0001 -> 0x3D800000.
  - 0x8000 -> 0xC5000000.
  - 0x0000 -> 0x00000000.
  - All with out_inexact=0 and 3-cycle latency at out_ready=1.
- Back-to-back stream: 100 random inputs with in_valid=1 and out_ready=1 -> one result per cycle, matches reference model, tags in order.
- Backpressure:
  - Hold out_ready=0 and offer 4 samples -> in_ready drops after 3 accepted; outputs stay stable.
  - Release out_ready -> results emerge in order with no loss or duplication.
- Rounding (INT_WIDTH=24, FRACT_WIDTH=8, SIGNED=0, macro defined):
  - 0x01000001 -> 0x47800000 (tie, even).
  - 0x01000003 -> 0x47800002 (tie, round up).
  - 0x01FFFFFF -> 0x48000000 (mantissa carry into exponent).
  - All three with out_inexact=1.
  - Without the macro: 0x01000003 -> 0x47800001 and 0x01FFFFFF -> 0x47FFFFFF.
- Reset mid-operation:
  - Pulse rst_n low for a partial cycle with 3 samples in flight -> out_valid falls immediately, no stale output after release, in_ready=1.
